axi_slave128_rslice: RTL
========================

Name: axi_slave128_rslice

Overview:
Full AXI4 register slice placed directly upstream of the 128-bit memory slave wrapper. It breaks every combinational path (valid/payload forward, ready backward) between the SoC interconnect and the slave on all five channels. It does this without losing throughput: one beat per cycle sustained per channel. Each cut channel uses a two-entry skid buffer, so all ready outputs are driven from flops.

Parameters:
AXI_ADDR_WIDTH, 32, address width of AW/AR.
AXI_DATA_WIDTH, 128, W/R data width; strobe width is AXI_DATA_WIDTH/8.
AXI_ID_WIDTH, 8, ID width on AW/AR/B/R.
CUT_MASK, 5'b11111, per-channel enable bits [0]=AW [1]=W [2]=B [3]=AR [4]=R. A bit set instantiates a skid buffer; a bit cleared makes that channel a pure wire passthrough.

Ports:
aclk  input  1  clock; all flops on rising edge.
arst_n  input  1  asynchronous active-low reset.
slv  AXI_BUS.Slave  interface  upstream side, facing the interconnect.
mst  AXI_BUS.Master  interface  downstream side, driving the memory slave wrapper.

Behaviour:
- Clocking/reset: one clock, aclk. Reset is asynchronous and active-low on arst_n, released synchronously by the surrounding reset logic.
- Channel direction:
  - AW/W/AR flow from slv to mst.
  - B/R flow from mst to slv.
  - The payload is every signal of the channel except valid/ready: AW/AR = id, addr, len, size, burst, lock, cache, prot, qos, region, user; W = data, strb, last, user; B = id, resp, user; R = id, data, resp, last, user.
- Skid buffer per cut channel: main register (m_vld, m_pl) and skid register (s_vld, s_pl).
  - out_valid = m_vld; out_payload = m_pl.
  - in_ready = ~s_vld, driven from a flop.
- Transfers: in_hs = in_valid & in_ready; out_hs = m_vld & out_ready.
- Update rules, evaluated in the same cycle:
  - in_hs with m empty, or with out_hs: m <= in. A skid entry, if present, is never bypassed: if s_vld & out_hs then m <= s first.
  - in_hs while m full and no out_hs: s <= in; the next cycle in_ready = 0.
  - out_hs with s_vld: m <= s, s_vld <= 0; in_ready returns to 1 the next cycle.
  - out_hs with no s and no in_hs: m_vld <= 0.
  - Simultaneous in_hs and out_hs with s empty: m <= in, m_vld stays 1 (streaming, 1 beat/cycle).
  - s_vld and in_hs cannot coincide, because in_ready = 0.
- Latency: 1 cycle from in_hs to out_valid for a cut channel; 0 cycles for an uncut channel.
- Ordering: beats are delivered strictly in order per channel. No reordering across channels and no AW/W coupling; the slice is transparent to protocol. WLAST/RLAST are carried unmodified.
- Stability: out_payload changes only when m is loaded; it is held while out_valid & ~out_ready (AXI stability rule).
- Reset values for every cut channel:
  - out_valid 0 (slv.b_valid, slv.r_valid, mst.aw_valid, mst.w_valid, mst.ar_valid).
  - in_ready 0 (slv.aw_ready, slv.w_ready, slv.ar_ready, mst.b_ready, mst.r_ready).
  - Payload flops reset to 0.
- Out of reset: in_ready rises to 1 on the first aclk edge after arst_n deassertion.
- Reset mid-transfer: all buffered beats are discarded and every valid drops asynchronously. Upstream and downstream are reset together by system design; the block takes no recovery action.
- Full condition: with both entries occupied and out_ready = 0, exactly two beats are held and in_ready = 0 until the downstream accepts.
- Uncut channel: out_valid = in_valid, in_ready = out_ready, payload wired through.

Decomposition:
- Package axi_slice_pkg:
  - typedefs aw_chan_t, w_chan_t, b_chan_t, ar_chan_t, r_chan_t as packed structs, parameterised through localparam widths derived from AXI_*_WIDTH.
  - constants CUT_AW=0, CUT_W=1, CUT_B=2, CUT_AR=3, CUT_R=4.
- Sub-module axi_skid_buf: parameters PL_W and BYPASS; ports aclk, arst_n, in_valid/in_ready/in_pl, out_valid/out_ready/out_pl. It is instantiated five times with generate on CUT_MASK. The top level only packs and unpacks the structs from the interface.

Test Plan:
- Reset release, then idle: all five out_valids are 0; all five in_readys are 0 during reset and 1 one cycle after arst_n rises.
- AW single beat (id=8'h3C, addr=32'h8000_0040, len=0) with mst.aw_ready=1: mst.aw_valid is asserted exactly 1 cycle after the slv handshake with identical fields; slv.aw_ready stays 1 throughout.
- W burst of 16 beats (data=i, last on beat 15) with mst.w_ready=1: 16 back-to-back outputs with no bubbles, in order, w_last on the 16th beat only, 1-cycle latency.
- R backpressure: mst returns 4 beats; slv.r_ready is 0 for cycles 2–5.
  - mst.r_ready drops after the 2nd beat is buffered.
  - No beat is lost or duplicated; rid/rdata/rlast match in order.
  - slv.r_data is stable while stalled.
- Simultaneous push/pop with the skid full: fill both entries, then in the same cycle raise out_ready while offering a new beat. Required: the new beat is refused (in_ready=0), the skid moves to main, and in_ready is 1 the next cycle.
- Assert arst_n low mid W burst (beat 5 of 8): mst.w_valid and slv.b_valid go low immediately; after release no stale beat appears on any channel.

Source files
------------

// File: rtl/axi_slice_pkg.sv
// Purpose : shared channel payload types and channel-select constants for the AXI register slice.
// Latency : n/a (types and constants only).
// Backpressure: n/a.
package axi_slice_pkg;

  // Widths of the 128-bit memory-slave AXI port. Payload structs are sized from these.
  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 128;
  localparam int AXI_ID_W   = 8;
  localparam int AXI_USER_W = 1;
  localparam int AXI_STRB_W = AXI_DATA_W / 8;

  // Bit positions inside CUT_MASK.
  localparam int CUT_AW = 0;
  localparam int CUT_W  = 1;
  localparam int CUT_B  = 2;
  localparam int CUT_AR = 3;
  localparam int CUT_R  = 4;

  typedef struct packed {
    logic [AXI_ID_W-1:0]   id;
    logic [AXI_ADDR_W-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
    logic                  lock;
    logic [3:0]            cache;
    logic [2:0]            prot;
    logic [3:0]            qos;
    logic [3:0]            region;
    logic [AXI_USER_W-1:0] user;
  } aw_chan_t;

  typedef struct packed {
    logic [AXI_DATA_W-1:0] data;
    logic [AXI_STRB_W-1:0] strb;
    logic                  last;
    logic [AXI_USER_W-1:0] user;
  } w_chan_t;

  typedef struct packed {
    logic [AXI_ID_W-1:0]   id;
    logic [1:0]            resp;
    logic [AXI_USER_W-1:0] user;
  } b_chan_t;

  typedef struct packed {
    logic [AXI_ID_W-1:0]   id;
    logic [AXI_ADDR_W-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
    logic                  lock;
    logic [3:0]            cache;
    logic [2:0]            prot;
    logic [3:0]            qos;
    logic [3:0]            region;
    logic [AXI_USER_W-1:0] user;
  } ar_chan_t;

  typedef struct packed {
    logic [AXI_ID_W-1:0]   id;
    logic [AXI_DATA_W-1:0] data;
    logic [1:0]            resp;
    logic                  last;
    logic [AXI_USER_W-1:0] user;
  } r_chan_t;

endpackage

// File: rtl/axi_bus_if.sv
// Purpose : AXI4 bus bundle with Master/Slave views.
// Latency : n/a (wiring only).
// Backpressure: standard AXI valid/ready per channel.
interface AXI_BUS #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 128,
  parameter int AXI_ID_WIDTH   = 8,
  parameter int AXI_USER_WIDTH = 1
) ();
  localparam int AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;

  logic [AXI_ID_WIDTH-1:0]   aw_id;
  logic [AXI_ADDR_WIDTH-1:0] aw_addr;
  logic [7:0]                aw_len;
  logic [2:0]                aw_size;
  logic [1:0]                aw_burst;
  logic                      aw_lock;
  logic [3:0]                aw_cache;
  logic [2:0]                aw_prot;
  logic [3:0]                aw_qos;
  logic [3:0]                aw_region;
  logic [AXI_USER_WIDTH-1:0] aw_user;
  logic                      aw_valid;
  logic                      aw_ready;

  logic [AXI_DATA_WIDTH-1:0] w_data;
  logic [AXI_STRB_WIDTH-1:0] w_strb;
  logic                      w_last;
  logic [AXI_USER_WIDTH-1:0] w_user;
  logic                      w_valid;
  logic                      w_ready;

  logic [AXI_ID_WIDTH-1:0]   b_id;
  logic [1:0]                b_resp;
  logic [AXI_USER_WIDTH-1:0] b_user;
  logic                      b_valid;
  logic                      b_ready;

  logic [AXI_ID_WIDTH-1:0]   ar_id;
  logic [AXI_ADDR_WIDTH-1:0] ar_addr;
  logic [7:0]                ar_len;
  logic [2:0]                ar_size;
  logic [1:0]                ar_burst;
  logic                      ar_lock;
  logic [3:0]                ar_cache;
  logic [2:0]                ar_prot;
  logic [3:0]                ar_qos;
  logic [3:0]                ar_region;
  logic [AXI_USER_WIDTH-1:0] ar_user;
  logic                      ar_valid;
  logic                      ar_ready;

  logic [AXI_ID_WIDTH-1:0]   r_id;
  logic [AXI_DATA_WIDTH-1:0] r_data;
  logic [1:0]                r_resp;
  logic                      r_last;
  logic [AXI_USER_WIDTH-1:0] r_user;
  logic                      r_valid;
  logic                      r_ready;

  modport Master (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
           aw_qos, aw_region, aw_user, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_last, w_user, w_valid,
    input  w_ready,
    input  b_id, b_resp, b_user, b_valid,
    output b_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
           ar_qos, ar_region, ar_user, ar_valid,
    input  ar_ready,
    input  r_id, r_data, r_resp, r_last, r_user, r_valid,
    output r_ready
  );

  modport Slave (
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
           aw_qos, aw_region, aw_user, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_last, w_user, w_valid,
    output w_ready,
    output b_id, b_resp, b_user, b_valid,
    input  b_ready,
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
           ar_qos, ar_region, ar_user, ar_valid,
    output ar_ready,
    output r_id, r_data, r_resp, r_last, r_user, r_valid,
    input  r_ready
  );

endinterface

// File: rtl/axi_skid_buf.sv
// Purpose : two-entry skid buffer cutting valid/payload forward and ready backward paths.
// Latency : 1 cycle in_valid->out_valid (0 when BYPASS); sustains 1 beat/cycle.
// Backpressure: in_ready is a flop, low only while both entries are full (or in reset).
//
// Ports: aclk/arst_n clock and async active-low reset; in_valid/in_ready/in_pl upstream
// handshake and payload; out_valid/out_ready/out_pl downstream handshake and payload.
module axi_skid_buf #(
  parameter int PL_W   = 8,
  parameter bit BYPASS = 1'b0
) (
  input  logic            aclk,
  input  logic            arst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [PL_W-1:0] in_pl,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PL_W-1:0] out_pl
);

  if (BYPASS) begin : g_wire

    assign out_valid = in_valid;
    assign in_ready  = out_ready;
    assign out_pl    = in_pl;

    // Clock and reset are not needed on a passthrough channel.
    logic unused_clk_rst;
    assign unused_clk_rst = aclk ^ arst_n;

  end else begin : g_cut

    logic            m_vld, m_vld_d;
    logic            s_vld, s_vld_d;
    logic [PL_W-1:0] m_pl, m_pl_d;
    logic [PL_W-1:0] s_pl, s_pl_d;
    logic            rdy_q;
    logic            in_hs, out_hs;

    assign in_hs     = in_valid & rdy_q;
    assign out_hs    = m_vld & out_ready;
    assign out_valid = m_vld;
    assign out_pl    = m_pl;
    assign in_ready  = rdy_q;

    always_comb begin
      m_vld_d = m_vld;
      s_vld_d = s_vld;
      m_pl_d  = m_pl;
      s_pl_d  = s_pl;
      if (out_hs) begin
        if (s_vld) begin
          // Skid entry is older than anything upstream; it always drains first.
          // in_hs cannot be set here because in_ready is low while s is held.
          m_pl_d  = s_pl;
          s_vld_d = 1'b0;
        end else if (in_hs) begin
          m_pl_d  = in_pl;          // streaming: m stays valid
        end else begin
          m_vld_d = 1'b0;
        end
      end else if (in_hs) begin
        if (m_vld) begin
          s_pl_d  = in_pl;          // main is stalled, park the beat
          s_vld_d = 1'b1;
        end else begin
          m_pl_d  = in_pl;
          m_vld_d = 1'b1;
        end
      end
    end

    // rdy_q tracks ~s_vld one cycle ahead so in_ready is a pure flop output.
    // It resets low and rises on the first edge after reset release.
    always_ff @(posedge aclk or negedge arst_n) begin
      if (!arst_n) begin
        m_vld <= 1'b0;
        s_vld <= 1'b0;
        m_pl  <= '0;
        s_pl  <= '0;
        rdy_q <= 1'b0;
      end else begin
        m_vld <= m_vld_d;
        s_vld <= s_vld_d;
        m_pl  <= m_pl_d;
        s_pl  <= s_pl_d;
        rdy_q <= ~s_vld_d;
      end
    end

  end

endmodule

// File: rtl/axi_slave128_rslice.sv
// Purpose : full AXI4 register slice in front of the 128-bit memory slave wrapper.
// Latency : 1 cycle per cut channel, 0 per uncut channel; 1 beat/cycle sustained.
// Backpressure: each cut channel absorbs up to 2 beats; upstream ready comes from a flop.
//
// Ports: aclk clock; arst_n async active-low reset; slv = interconnect-facing slave side
// (AW/W/AR in, B/R out); mst = memory-facing master side (AW/W/AR out, B/R in).
// CUT_MASK bit set = skid buffer on that channel, clear = wire ([0]AW [1]W [2]B [3]AR [4]R).
module axi_slave128_rslice
  import axi_slice_pkg::*;
#(
  parameter int         AXI_ADDR_WIDTH = AXI_ADDR_W,
  parameter int         AXI_DATA_WIDTH = AXI_DATA_W,
  parameter int         AXI_ID_WIDTH   = AXI_ID_W,
  parameter logic [4:0] CUT_MASK       = 5'b11111
) (
  input  logic   aclk,
  input  logic   arst_n,
  AXI_BUS.Slave  slv,
  AXI_BUS.Master mst
);

  // The payload structs are sized from the package; a mismatching override would
  // silently truncate fields, so stop elaboration instead.
  if (AXI_ADDR_WIDTH != AXI_ADDR_W || AXI_DATA_WIDTH != AXI_DATA_W ||
      AXI_ID_WIDTH != AXI_ID_W) begin : g_bad_width
    $error("axi_slave128_rslice: AXI widths must match axi_slice_pkg");
  end

  aw_chan_t aw_in, aw_out;
  w_chan_t  w_in,  w_out;
  b_chan_t  b_in,  b_out;
  ar_chan_t ar_in, ar_out;
  r_chan_t  r_in,  r_out;

  // ---------------- AW: slv -> mst ----------------
  assign aw_in.id     = slv.aw_id;
  assign aw_in.addr   = slv.aw_addr;
  assign aw_in.len    = slv.aw_len;
  assign aw_in.size   = slv.aw_size;
  assign aw_in.burst  = slv.aw_burst;
  assign aw_in.lock   = slv.aw_lock;
  assign aw_in.cache  = slv.aw_cache;
  assign aw_in.prot   = slv.aw_prot;
  assign aw_in.qos    = slv.aw_qos;
  assign aw_in.region = slv.aw_region;
  assign aw_in.user   = slv.aw_user;

  axi_skid_buf #(.PL_W($bits(aw_chan_t)), .BYPASS(!CUT_MASK[CUT_AW])) u_aw (
    .aclk      (aclk),
    .arst_n    (arst_n),
    .in_valid  (slv.aw_valid),
    .in_ready  (slv.aw_ready),
    .in_pl     (aw_in),
    .out_valid (mst.aw_valid),
    .out_ready (mst.aw_ready),
    .out_pl    (aw_out)
  );

  assign mst.aw_id     = aw_out.id;
  assign mst.aw_addr   = aw_out.addr;
  assign mst.aw_len    = aw_out.len;
  assign mst.aw_size   = aw_out.size;
  assign mst.aw_burst  = aw_out.burst;
  assign mst.aw_lock   = aw_out.lock;
  assign mst.aw_cache  = aw_out.cache;
  assign mst.aw_prot   = aw_out.prot;
  assign mst.aw_qos    = aw_out.qos;
  assign mst.aw_region = aw_out.region;
  assign mst.aw_user   = aw_out.user;

  // ---------------- W: slv -> mst ----------------
  assign w_in.data = slv.w_data;
  assign w_in.strb = slv.w_strb;
  assign w_in.last = slv.w_last;
  assign w_in.user = slv.w_user;

  axi_skid_buf #(.PL_W($bits(w_chan_t)), .BYPASS(!CUT_MASK[CUT_W])) u_w (
    .aclk      (aclk),
    .arst_n    (arst_n),
    .in_valid  (slv.w_valid),
    .in_ready  (slv.w_ready),
    .in_pl     (w_in),
    .out_valid (mst.w_valid),
    .out_ready (mst.w_ready),
    .out_pl    (w_out)
  );

  assign mst.w_data = w_out.data;
  assign mst.w_strb = w_out.strb;
  assign mst.w_last = w_out.last;
  assign mst.w_user = w_out.user;

  // ---------------- B: mst -> slv ----------------
  assign b_in.id   = mst.b_id;
  assign b_in.resp = mst.b_resp;
  assign b_in.user = mst.b_user;

  axi_skid_buf #(.PL_W($bits(b_chan_t)), .BYPASS(!CUT_MASK[CUT_B])) u_b (
    .aclk      (aclk),
    .arst_n    (arst_n),
    .in_valid  (mst.b_valid),
    .in_ready  (mst.b_ready),
    .in_pl     (b_in),
    .out_valid (slv.b_valid),
    .out_ready (slv.b_ready),
    .out_pl    (b_out)
  );

  assign slv.b_id   = b_out.id;
  assign slv.b_resp = b_out.resp;
  assign slv.b_user = b_out.user;

  // ---------------- AR: slv -> mst ----------------
  assign ar_in.id     = slv.ar_id;
  assign ar_in.addr   = slv.ar_addr;
  assign ar_in.len    = slv.ar_len;
  assign ar_in.size   = slv.ar_size;
  assign ar_in.burst  = slv.ar_burst;
  assign ar_in.lock   = slv.ar_lock;
  assign ar_in.cache  = slv.ar_cache;
  assign ar_in.prot   = slv.ar_prot;
  assign ar_in.qos    = slv.ar_qos;
  assign ar_in.region = slv.ar_region;
  assign ar_in.user   = slv.ar_user;

  axi_skid_buf #(.PL_W($bits(ar_chan_t)), .BYPASS(!CUT_MASK[CUT_AR])) u_ar (
    .aclk      (aclk),
    .arst_n    (arst_n),
    .in_valid  (slv.ar_valid),
    .in_ready  (slv.ar_ready),
    .in_pl     (ar_in),
    .out_valid (mst.ar_valid),
    .out_ready (mst.ar_ready),
    .out_pl    (ar_out)
  );

  assign mst.ar_id     = ar_out.id;
  assign mst.ar_addr   = ar_out.addr;
  assign mst.ar_len    = ar_out.len;
  assign mst.ar_size   = ar_out.size;
  assign mst.ar_burst  = ar_out.burst;
  assign mst.ar_lock   = ar_out.lock;
  assign mst.ar_cache  = ar_out.cache;
  assign mst.ar_prot   = ar_out.prot;
  assign mst.ar_qos    = ar_out.qos;
  assign mst.ar_region = ar_out.region;
  assign mst.ar_user   = ar_out.user;

  // ---------------- R: mst -> slv ----------------
  assign r_in.id   = mst.r_id;
  assign r_in.data = mst.r_data;
  assign r_in.resp = mst.r_resp;
  assign r_in.last = mst.r_last;
  assign r_in.user = mst.r_user;

  axi_skid_buf #(.PL_W($bits(r_chan_t)), .BYPASS(!CUT_MASK[CUT_R])) u_r (
    .aclk      (aclk),
    .arst_n    (arst_n),
    .in_valid  (mst.r_valid),
    .in_ready  (mst.r_ready),
    .in_pl     (r_in),
    .out_valid (slv.r_valid),
    .out_ready (slv.r_ready),
    .out_pl    (r_out)
  );

  assign slv.r_id   = r_out.id;
  assign slv.r_data = r_out.data;
  assign slv.r_resp = r_out.resp;
  assign slv.r_last = r_out.last;
  assign slv.r_user = r_out.user;

endmodule
